hazard_ctrl: RTL

- Stall/flush/redirect controller for the 5-stage MIPS pipeline.
- Sequences the PC register through its stall input (hold) and its next-PC select (sequential pc+4 vs. redirect target).
- Sources of stall: Tuse/Tnew register hazards, and a multiply/divide busy timer that models the MDU latency.
- Sits between the D-stage decoder, the E/M pipeline registers and the PC/IF-ID/ID-EX registers.

---
 rtl/hazard_pkg.sv | 40 ++++
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl_md_busy_timer.sv | 58 +++++
 rtl/hazard_ctrl.sv | 64 ++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants, encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned T_W   = 2;

  // Tuse value meaning "operand not read"
  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  // Tnew encodings: cycles until the producer's result is available
  localparam logic [T_W-1:0] TNEW_READY = 2'd0;
  localparam logic [T_W-1:0] TNEW_ONE   = 2'd1;
  localparam logic [T_W-1:0] TNEW_TWO   = 2'd2;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Multiply/divide op select carried alongside e_md_start
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // One source operand stalls when a younger-than-needed producer targets it
  function automatic logic reg_hazard(
    input logic [REG_W-1:0] src,
    input logic [T_W-1:0]   tuse,
    input logic [REG_W-1:0] e_wa,
    input logic [T_W-1:0]   e_tnew,
    input logic [REG_W-1:0] m_wa,
    input logic [T_W-1:0]   m_tnew
  );
    return (src != REG_ZERO) &&
           (((src == e_wa) && (e_tnew > tuse)) ||
            ((src == m_wa) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/pipeline-side signal bundle of the hazard controller.
// Optional stall_cycles counter appears when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic [T_W-1:0]   d_tuse_rs;
  logic [T_W-1:0]   d_tuse_rt;
  logic             d_is_md;
  logic [REG_W-1:0] e_wa;
  logic [T_W-1:0]   e_tnew;
  logic [REG_W-1:0] m_wa;
  logic [T_W-1:0]   m_tnew;
  logic             e_md_start;
  logic             e_md_div;
  logic             d_branch_taken;
  logic             stall;
  logic             flush_e;
  logic             pccon;
  logic             md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]      stall_cycles;
`endif

  // Pipeline / decoder side
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md, e_wa, e_tnew,
           m_wa, m_tnew, e_md_start, e_md_div, d_branch_taken,
    input  stall, flush_e, pccon, md_busy
`ifdef HAZARD_PERF_EN
    , input stall_cycles
`endif
  );

  // Hazard controller side
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md, e_wa, e_tnew,
           m_wa, m_tnew, e_md_start, e_md_div, d_branch_taken,
    output stall, flush_e, pccon, md_busy
`ifdef HAZARD_PERF_EN
    , output stall_cycles
`endif
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// MDU latency model: busy for exactly N cycles after a mult/div start.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load on start from IDLE, count down in BUSY, starts in BUSY ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = (is_div == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline.
// Define HAZARD_PERF_EN to add the 32-bit stall_cycles performance counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  logic md_busy;
  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall_any;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.e_md_start),
    .is_div (bus.e_md_div),
    .busy   (md_busy)
  );

  // Tuse/Tnew comparators for both source operands plus the MDU interlock
  always_comb begin
    stall_rs  = reg_hazard(bus.d_rs, bus.d_tuse_rs, bus.e_wa, bus.e_tnew,
                           bus.m_wa, bus.m_tnew);
    stall_rt  = reg_hazard(bus.d_rt, bus.d_tuse_rt, bus.e_wa, bus.e_tnew,
                           bus.m_wa, bus.m_tnew);
    stall_md  = bus.d_is_md && (bus.e_md_start || md_busy);
    stall_any = reset && (stall_rs || stall_rt || stall_md);
  end

  // Redirect only when the pipeline actually advances
  assign bus.stall   = stall_any;
  assign bus.flush_e = stall_any;
  assign bus.pccon   = reset && bus.d_branch_taken && !stall_any;
  assign bus.md_busy = md_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  // Count clock edges that see a stall; wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall_any) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`endif

endmodule
